// File: rtl/obj_linebuf_ab.sv
// -----------------------------------------------------------------------------
// obj_linebuf_ab
//
// Object line-buffer datapath with an A/B double line buffer. A 32-bit object
// ROM word is loaded into a shifter and serialised into eight 4-bit pixels.
// Opaque pixels are written as {palette, nibble} into the back (write) bank
// while the front (read) bank is scanned out at hcount. Every location that is
// read is cleared in the same cycle, so each line starts out transparent.
//
// Ports
//   clk            system clock
//   Reset_n        asynchronous active-low reset
//   Cen            pixel clock enable; nothing changes on cycles with Cen=0
//   PLOAD_RSHIFTn  0 = load shifter from rom_data, 1 = shift one pixel
//   RL_Sel         shift direction at load (1 = MSB nibble first)
//   AB_Sel         write bank select; read bank is ~AB_Sel
//   VLK            pixel write enable for the current shift cycle
//   rom_data       eight 4-bit pixels
//   obj_pal        palette bank, captured at load
//   obj_x          start x of the loaded word, captured at load
//   hcount         scan-out read address
//   pix_out        {pal, nibble} read one Cen after hcount was presented
//   pix_valid      pix_out comes from a bank written since reset
// -----------------------------------------------------------------------------
module obj_linebuf_ab #(
  parameter int XW   = 9,
  parameter int PALW = 3
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              Cen,
  input  logic              PLOAD_RSHIFTn,
  input  logic              RL_Sel,
  input  logic              AB_Sel,
  input  logic              VLK,
  input  logic [31:0]       rom_data,
  input  logic [PALW-1:0]   obj_pal,
  input  logic [XW-1:0]     obj_x,
  input  logic [XW-1:0]     hcount,
  output logic [PALW+3:0]   pix_out,
  output logic              pix_valid
);

  localparam int PW    = PALW + 4;
  localparam int DEPTH = 1 << XW;

  // Line buffer banks: A is bank 0, B is bank 1.
  logic [PW-1:0] mem_a [DEPTH];
  logic [PW-1:0] mem_b [DEPTH];

  // Serialiser state
  logic [31:0]     shreg;
  logic            dir;
  logic [PALW-1:0] pal;
  logic [XW-1:0]   wr_x;
  logic [3:0]      cnt;

  // Bank bookkeeping
  logic            ab_q;     // AB_Sel as of the last Cen
  logic            swapped;  // an AB_Sel change has been seen since reset

  logic            do_load;
  logic            ab_chg;
  logic            do_shift;
  logic [3:0]      nib;
  logic            obj_we;
  logic [PW-1:0]   obj_wdata;
  logic [PW-1:0]   rd_data;

  logic            we_a;
  logic [XW-1:0]   addr_a;
  logic [PW-1:0]   data_a;
  logic            we_b;
  logic [XW-1:0]   addr_b;
  logic [PW-1:0]   data_b;

  always_comb begin
    do_load   = Cen & ~PLOAD_RSHIFTn;
    ab_chg    = Cen & (AB_Sel != ab_q);
    // A bank swap terminates the word in flight, so no pixel goes out on it.
    do_shift  = Cen & PLOAD_RSHIFTn & (cnt != 4'd0) & ~ab_chg;
    nib       = dir ? shreg[31:28] : shreg[3:0];
    // Transparent nibbles are never written so earlier opaque pixels win.
    obj_we    = do_shift & VLK & (nib != 4'd0);
    obj_wdata = {pal, nib};
    rd_data   = AB_Sel ? mem_a[hcount] : mem_b[hcount];
  end

  // Each bank has one write port shared between object writes (when it is the
  // back bank) and clear-after-read (when it is the front bank). The two users
  // always sit in opposite banks, so they never compete for a port.
  always_comb begin
    we_a   = AB_Sel ? Cen    : obj_we;
    addr_a = AB_Sel ? hcount : wr_x;
    data_a = AB_Sel ? '0     : obj_wdata;
    we_b   = AB_Sel ? obj_we : Cen;
    addr_b = AB_Sel ? wr_x   : hcount;
    data_b = AB_Sel ? obj_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= data_a;
  end

  always_ff @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= data_b;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shreg     <= '0;
      dir       <= 1'b1;
      pal       <= '0;
      wr_x      <= '0;
      cnt       <= '0;
      ab_q      <= 1'b0;
      swapped   <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else if (Cen) begin
      ab_q    <= AB_Sel;
      pix_out <= rd_data;
      // pix_valid lags the first swap by one Cen so it lines up with the
      // first pixel read from the freshly swapped-in bank.
      pix_valid <= swapped;
      if (ab_chg) swapped <= 1'b1;

      if (do_load) begin
        shreg <= rom_data;
        dir   <= RL_Sel;
        pal   <= obj_pal;
        wr_x  <= obj_x;
        cnt   <= 4'd8;
      end else if (ab_chg) begin
        cnt <= 4'd0;
      end else if (do_shift) begin
        shreg <= dir ? {shreg[27:0], 4'h0} : {4'h0, shreg[31:4]};
        wr_x  <= wr_x + 1'b1;
        cnt   <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_obj_linebuf_ab.sv
module tb_obj_linebuf_ab;
  localparam int XW   = 9;
  localparam int PALW = 3;
  localparam int PW   = PALW + 4;
  localparam logic [XW-1:0] PARK = 9'd400;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            Cen = 1'b0;
  logic            PLOAD_RSHIFTn = 1'b1;
  logic            RL_Sel = 1'b1;
  logic            AB_Sel = 1'b0;
  logic            VLK = 1'b0;
  logic [31:0]     rom_data = '0;
  logic [PALW-1:0] obj_pal = '0;
  logic [XW-1:0]   obj_x = '0;
  logic [XW-1:0]   hcount = PARK;
  logic [PW-1:0]   pix_out;
  logic            pix_valid;

  int checks = 0;
  int errors = 0;

  obj_linebuf_ab #(.XW(XW), .PALW(PALW)) dut (
    .clk(clk), .Reset_n(Reset_n), .Cen(Cen), .PLOAD_RSHIFTn(PLOAD_RSHIFTn),
    .RL_Sel(RL_Sel), .AB_Sel(AB_Sel), .VLK(VLK), .rom_data(rom_data),
    .obj_pal(obj_pal), .obj_x(obj_x), .hcount(hcount),
    .pix_out(pix_out), .pix_valid(pix_valid)
  );

  // ---------------------------------------------------------------- drivers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic [XW-1:0] x,
                           input logic [PALW-1:0] p, input logic rl);
    Cen = 1'b1; PLOAD_RSHIFTn = 1'b0;
    rom_data = d; obj_x = x; obj_pal = p; RL_Sel = rl;
    cyc();
    PLOAD_RSHIFTn = 1'b1;
  endtask

  task automatic shift_n(input int n, input logic vlk);
    Cen = 1'b1; PLOAD_RSHIFTn = 1'b1; VLK = vlk;
    repeat (n) cyc();
    VLK = 1'b0;
  endtask

  task automatic swap_bank();
    Cen = 1'b1; PLOAD_RSHIFTn = 1'b1; hcount = PARK;
    AB_Sel = ~AB_Sel;
    cyc();
  endtask

  task automatic clear_front();
    Cen = 1'b1; PLOAD_RSHIFTn = 1'b1;
    for (int i = 0; i < (1 << XW); i++) begin
      hcount = XW'(i);
      cyc();
    end
    hcount = PARK;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) cyc();
    checks++;
    if (pix_out !== '0) begin
      errors++; $display("FAIL reset_pix_out got %h exp 00", pix_out);
    end
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pix_valid got %b exp 0", pix_valid);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    Cen = 1'b1; PLOAD_RSHIFTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (pix_valid !== 1'b0) begin
        errors++; $display("FAIL valid_before_swap cyc=%0d got %b exp 0", i, pix_valid);
      end
    end
  endtask

  task automatic test_valid_rise();
    swap_bank();
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL valid_on_swap got %b exp 0", pix_valid);
    end
    cyc();
    checks++;
    if (pix_valid !== 1'b1) begin
      errors++; $display("FAIL valid_after_swap got %b exp 1", pix_valid);
    end
    // Wipe both banks so later scans start from a known transparent buffer.
    clear_front();
    swap_bank();
    clear_front();
  endtask

  task automatic test_msb_first();
    logic [PW-1:0] exp_v [9] = '{7'h51, 7'h52, 7'h53, 7'h54, 7'h55, 7'h56, 7'h57, 7'h58, 7'h00};
    load_word(32'h12345678, 9'd10, 3'd5, 1'b1);
    shift_n(8, 1'b1);
    swap_bank();
    for (int i = 0; i < 9; i++) begin
      hcount = XW'(10 + i); cyc();
      checks++;
      if (pix_out !== exp_v[i]) begin
        errors++; $display("FAIL msb_first x=%0d got %h exp %h", 10 + i, pix_out, exp_v[i]);
      end
    end
  endtask

  task automatic test_lsb_first_clear();
    logic [PW-1:0] exp_v [8] = '{7'h58, 7'h57, 7'h56, 7'h55, 7'h54, 7'h53, 7'h52, 7'h51};
    load_word(32'h12345678, 9'd10, 3'd5, 1'b0);
    shift_n(8, 1'b1);
    swap_bank();
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(10 + i); cyc();
      checks++;
      if (pix_out !== exp_v[i]) begin
        errors++; $display("FAIL lsb_first x=%0d got %h exp %h", 10 + i, pix_out, exp_v[i]);
      end
    end
    swap_bank();
    swap_bank();
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(10 + i); cyc();
      checks++;
      if (pix_out !== 7'h00) begin
        errors++; $display("FAIL clear_after_read x=%0d got %h exp 00", 10 + i, pix_out);
      end
    end
  endtask

  task automatic test_transparent();
    logic [PW-1:0] exp_v [8] = '{7'h21, 7'h7F, 7'h22, 7'h00, 7'h23, 7'h00, 7'h24, 7'h00};
    load_word(32'hF0000000, 9'd101, 3'd7, 1'b1);
    shift_n(8, 1'b1);
    load_word(32'h10203040, 9'd100, 3'd2, 1'b1);
    shift_n(8, 1'b1);
    swap_bank();
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(100 + i); cyc();
      checks++;
      if (pix_out !== exp_v[i]) begin
        errors++; $display("FAIL transparent x=%0d got %h exp %h", 100 + i, pix_out, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] exp_v [8] = '{7'h19, 7'h1A, 7'h1B, 7'h1C, 7'h1D, 7'h1E, 7'h1F, 7'h11};
    load_word(32'h9ABCDEF1, 9'd510, 3'd1, 1'b1);
    shift_n(8, 1'b1);
    swap_bank();
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(510 + i); cyc();
      checks++;
      if (pix_out !== exp_v[i]) begin
        errors++; $display("FAIL wrap x=%0d got %h exp %h", hcount, pix_out, exp_v[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [PW-1:0] exp_r [8] = '{7'h31, 7'h31, 7'h31, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    logic [PW-1:0] exp_s [8] = '{7'h65, 7'h65, 7'h65, 7'h65, 7'h65, 7'h00, 7'h00, 7'h00};
    // Reload after three pixels
    load_word(32'h11111111, 9'd200, 3'd3, 1'b1);
    shift_n(3, 1'b1);
    load_word(32'h22222222, 9'd220, 3'd4, 1'b1);
    shift_n(8, 1'b1);
    swap_bank();
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(200 + i); cyc();
      checks++;
      if (pix_out !== exp_r[i]) begin
        errors++; $display("FAIL reload_abort x=%0d got %h exp %h", 200 + i, pix_out, exp_r[i]);
      end
    end
    // Bank swap after five pixels
    load_word(32'h55555555, 9'd250, 3'd6, 1'b1);
    shift_n(5, 1'b1);
    swap_bank();
    shift_n(3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(250 + i); cyc();
      checks++;
      if (pix_out !== exp_s[i]) begin
        errors++; $display("FAIL swap_abort x=%0d got %h exp %h", 250 + i, pix_out, exp_s[i]);
      end
    end
    hcount = PARK;
  endtask

  task automatic test_vlk();
    logic [PW-1:0] exp_v [8] = '{7'h1A, 7'h1A, 7'h00, 7'h00, 7'h1A, 7'h1A, 7'h1A, 7'h1A};
    load_word(32'hAAAAAAAA, 9'd260, 3'd1, 1'b1);
    shift_n(2, 1'b1);
    shift_n(2, 1'b0);
    shift_n(4, 1'b1);
    swap_bank();
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(260 + i); cyc();
      checks++;
      if (pix_out !== exp_v[i]) begin
        errors++; $display("FAIL vlk_gate x=%0d got %h exp %h", 260 + i, pix_out, exp_v[i]);
      end
    end
  endtask

  task automatic test_cen_hold();
    load_word(32'h90000000, 9'd280, 3'd3, 1'b1);
    shift_n(8, 1'b1);
    swap_bank();
    hcount = 9'd280; cyc();
    checks++;
    if (pix_out !== 7'h39) begin
      errors++; $display("FAIL cen_read got %h exp 39", pix_out);
    end
    // With Cen low, neither the load nor the new hcount may take effect.
    Cen = 1'b0; PLOAD_RSHIFTn = 1'b0; rom_data = 32'hFFFFFFFF; obj_x = 9'd290;
    hcount = 9'd281;
    repeat (4) cyc();
    checks++;
    if (pix_out !== 7'h39) begin
      errors++; $display("FAIL cen_hold got %h exp 39", pix_out);
    end
    hcount = PARK;
    shift_n(8, 1'b1);
    swap_bank();
    for (int i = 0; i < 2; i++) begin
      hcount = XW'(290 + i); cyc();
      checks++;
      if (pix_out !== 7'h00) begin
        errors++; $display("FAIL cen_no_load x=%0d got %h exp 00", 290 + i, pix_out);
      end
    end
    hcount = PARK;
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] exp_v [8] = '{7'h27, 7'h27, 7'h27, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    if (AB_Sel != 1'b1) swap_bank();
    // Marker pixel in bank 1 so pix_out is non-zero just before reset.
    load_word(32'h30000000, 9'd460, 3'd4, 1'b1);
    shift_n(8, 1'b1);
    swap_bank();
    load_word(32'h77777777, 9'd450, 3'd2, 1'b1);
    shift_n(2, 1'b1);
    hcount = 9'd460;
    shift_n(1, 1'b1);
    hcount = PARK;
    checks++;
    if (pix_out !== 7'h43) begin
      errors++; $display("FAIL pre_reset_pix got %h exp 43", pix_out);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (pix_out !== 7'h00) begin
      errors++; $display("FAIL async_reset_pix got %h exp 00", pix_out);
    end
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_valid got %b exp 0", pix_valid);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    shift_n(5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (pix_valid !== 1'b0) begin
        errors++; $display("FAIL valid_hold_low cyc=%0d got %b exp 0", i, pix_valid);
      end
    end
    swap_bank();
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL valid_swap_cen got %b exp 0", pix_valid);
    end
    cyc();
    checks++;
    if (pix_valid !== 1'b1) begin
      errors++; $display("FAIL valid_rise_again got %b exp 1", pix_valid);
    end
    for (int i = 0; i < 8; i++) begin
      hcount = XW'(450 + i); cyc();
      checks++;
      if (pix_out !== exp_v[i]) begin
        errors++; $display("FAIL reset_drop x=%0d got %h exp %h", 450 + i, pix_out, exp_v[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_valid_rise();
    test_msb_first();
    test_lsb_first_clear();
    test_transparent();
    test_wrap();
    test_abort();
    test_vlk();
    test_cen_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obj_linebuf_ab.md
# obj_linebuf_ab

Object line-buffer datapath driven by the object timing PAL outputs. It receives 32-bit object ROM words, serialises them into 4-bit pixels and writes them into the back half of an A/B double line buffer while the front half is scanned out. Each location is cleared as it is read, so every line starts from a transparent buffer. It sits between the object ROM fetch and the video mixer. It consumes PLOAD_RSHIFTn, RL_Sel, AB_Sel and VLK exactly as the sequencing PAL produces them.

## Interface
- XW, 9: line buffer address width (2^XW pixel positions, wraps modulo 2^XW)
- PALW, 3: palette bank width; pixel out width = PALW+4

- clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- Cen  in  1  pixel clock enable; all state advances only on clk cycles with Cen=1
- PLOAD_RSHIFTn  in  1  0 = load shifter from rom_data, 1 = shift one pixel
- RL_Sel  in  1  shift direction, sampled at load: 1 = MSB nibble first, 0 = LSB nibble first
- AB_Sel  in  1  write bank select; read bank = ~AB_Sel
- VLK  in  1  pixel write enable for the current shift cycle
- rom_data  in  32  eight 4-bit pixels
- obj_pal  in  PALW  palette bank, sampled at load
- obj_x  in  XW  start x of the loaded word, sampled at load
- hcount  in  XW  scan-out read address
- pix_out  out  PALW+4  {pal, nibble}; nibble 0 = transparent
- pix_valid  out  1  pix_out holds data from a buffer written since reset

## Operation
- Two RAM banks A/B, 2^XW x (PALW+4) each, one write and one read port per bank.
- Load (Cen & !PLOAD_RSHIFTn):
  - shreg <= rom_data; dir <= RL_Sel; pal <= obj_pal; wr_x <= obj_x; cnt <= 8.
  - A load while cnt>0 aborts the remaining pixels of the previous word.
- Shift (Cen & PLOAD_RSHIFTn & cnt>0):
  - Current nibble is shreg[31:28] when dir=1, or shreg[3:0] when dir=0.
  - If VLK=1 and nibble≠0: write {pal,nibble} at wr_x into bank AB_Sel.
  - Then always: shreg shifts by 4 toward the taken end with zero fill; wr_x <= wr_x+1 (mod 2^XW); cnt <= cnt-1.
  - VLK=0 skips the write but still advances. Transparent nibbles never overwrite, so the earlier-written opaque pixel keeps priority.
  - With cnt=0, shift cycles do nothing.
- Readout (every Cen):
  - Read bank ~AB_Sel at hcount. The data is registered to pix_out on the next Cen.
  - On the same Cen as the read, write 0 to that location (clear-after-read).
- Bank swap: AB_Sel is sampled every Cen. A change takes effect on that same Cen for both the write and read sides. cnt is forced to 0 unless that Cen is also a load; a load on a swap Cen targets the new write bank.
- Write and clear never collide: they always address opposite banks.
- pix_valid:
  - Held 0 after reset until the first AB_Sel change.
  - From the Cen after that change it is 1, and stays 1 until the next reset.

## Timing
- Reset values: pix_out=0, pix_valid=0, shreg=0, cnt=0, wr_x=0, pal=0, dir=1, sampled AB_Sel=0. RAM contents are not reset and are undefined until cleared by readout.
- Reset is asynchronous on assert and released synchronously to clk. A reset mid-word drops the word: cnt=0, no further writes.
- Load-to-first-write: first pixel written on the first shift Cen after load. Eight pixels are written over eight consecutive shift Cens.
- Read latency: pix_out reflects hcount presented on Cen n at Cen n+1. The clear of that location lands on Cen n.
- Non-Cen cycles: no state change, no RAM write, and outputs hold.
- wr_x wraps from 2^XW-1 to 0 within a word with no gap.

## Test plan
- Load rom_data=0x12345678, obj_x=10, pal=5, RL_Sel=1, then 8 shifts with VLK=1. Swap AB_Sel and scan hcount 10..17. Required pix_out = 0x51,0x52,…,0x58, then 0 at x=18.
- Same word with RL_Sel=0 → x=10..17 read 0x58,0x57,…,0x51. Rescan the same bank after a second swap pair with no writes → all 0 (clear-after-read).
- rom_data=0x10203040, obj_x=100: nibbles 0 leave prior contents. Pre-write 0x7F at x=101, then scan → x=101 still 0x7F.
- obj_x=510, 8 shifts → pixels at 510, 511, 0..5 (wrap).
- Reload after 3 shifts → only 3 pixels of the first word present. Toggle AB_Sel after 5 shifts of another word → remaining 3 pixels not written.
- Assert Reset_n=0 mid-word → pix_out=0 and pix_valid=0 immediately; pix_valid stays 0 through the next line until an AB_Sel change, then goes 1 the Cen after.
